// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared constants for the seven-segment display monitor.
//   Segment patterns are the active-low values of SEG_IN[6:0] (g..a).
//   CODE_BLANK / CODE_INVALID are the decoded nibbles for a dark digit
//   and for any pattern that is not a recognised numeral.
//   state_t is the capture FSM encoding used by seg7_mon.
package seg7_pkg;

   localparam logic [6:0] PAT_0     = 7'h40;
   localparam logic [6:0] PAT_1     = 7'h79;
   localparam logic [6:0] PAT_2     = 7'h24;
   localparam logic [6:0] PAT_3     = 7'h30;
   localparam logic [6:0] PAT_4     = 7'h19;
   localparam logic [6:0] PAT_5     = 7'h12;
   localparam logic [6:0] PAT_6     = 7'h02;
   localparam logic [6:0] PAT_7     = 7'h78;
   localparam logic [6:0] PAT_8     = 7'h00;
   localparam logic [6:0] PAT_9     = 7'h10;
   localparam logic [6:0] PAT_BLANK = 7'h7F;

   localparam logic [3:0] CODE_BLANK   = 4'hA;
   localparam logic [3:0] CODE_INVALID = 4'hF;

   typedef enum logic [1:0] {
      S_WAIT   = 2'd0,
      S_SETTLE = 2'd1,
      S_HOLD   = 2'd2
   } state_t;

endpackage

// File: rtl/seg7_enc.sv
// seg7_enc -- combinational seven-segment pattern decoder.
// Ports:
//   seg_in [7:0]  active-low segment bus, bit7 = dot, bits6:0 = g..a
//   code   [3:0]  0..9 for numerals, CODE_BLANK for all-dark, else CODE_INVALID
//   dot           1 when the dot segment is lit
module seg7_enc
   import seg7_pkg::*;
(
   input  logic [7:0] seg_in,
   output logic [3:0] code,
   output logic       dot
);

   always_comb begin
      dot = ~seg_in[7];
      case (seg_in[6:0])
         PAT_0:     code = 4'd0;
         PAT_1:     code = 4'd1;
         PAT_2:     code = 4'd2;
         PAT_3:     code = 4'd3;
         PAT_4:     code = 4'd4;
         PAT_5:     code = 4'd5;
         PAT_6:     code = 4'd6;
         PAT_7:     code = 4'd7;
         PAT_8:     code = 4'd8;
         PAT_9:     code = 4'd9;
         PAT_BLANK: code = CODE_BLANK;
         default:   code = CODE_INVALID;
      endcase
   end

endmodule

// File: rtl/seg7_mon.sv
// seg7_mon -- monitors a multiplexed seven-segment display bus and captures
// the value shown on each digit once the bus has been stable long enough.
// Parameters:
//   NDIG        number of multiplexed digits (1..8)
//   STABLE_CYC  consecutive stable synchronized cycles required to capture (2..255)
// Ports:
//   CLK          rising-edge clock
//   nRST         asynchronous active-low reset
//   SEG_IN [7:0] active-low segments, bit7 = dot
//   DIG_SEL      active-low digit enables, exactly one low = valid select
//   DOUT         decoded code per digit, digit i at [4i+3:4i]
//   DOT_OUT      last captured dot per digit
//   FRAME_VALID  one-cycle pulse once every digit has been captured
//   ERR          sticky invalid-capture flag
// Build option: define SEG7MON_ERR_EN to make ERR latch on a capture that
// decodes to CODE_INVALID; otherwise ERR is tied low.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_WAIT   | no valid select seen; waiting for exactly one digit enable
// S_SETTLE | counting cycles the (segments, select) pair stays unchanged
// S_HOLD   | pair captured; ignore it until the bus changes
module seg7_mon
   import seg7_pkg::*;
#(
   parameter int NDIG       = 4,
   parameter int STABLE_CYC = 4
) (
   input  logic                CLK,
   input  logic                nRST,
   input  logic [7:0]          SEG_IN,
   input  logic [NDIG-1:0]     DIG_SEL,
   output logic [4*NDIG-1:0]   DOUT,
   output logic [NDIG-1:0]     DOT_OUT,
   output logic                FRAME_VALID,
   output logic                ERR
);

   // Capture fires on the edge where the count would reach STABLE_CYC.
   localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYC - 1);

   logic [7:0]        seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
   logic [NDIG-1:0]   sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
   logic [7:0]        seg_ref_q, seg_ref_d;
   logic [NDIG-1:0]   sel_ref_q, sel_ref_d;
   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [4*NDIG-1:0] dout_q, dout_d;
   logic [NDIG-1:0]   dot_q, dot_d;
   logic [NDIG-1:0]   mask_q, mask_d;
   logic              fv_q, fv_d;
   logic              err_q, err_d;

   logic [NDIG-1:0]   sel_inv;
   logic              sel_valid;
   logic              pair_same;
   logic              capture;
   logic [3:0]        enc_code;
   logic              enc_dot;

   seg7_enc u_enc (
      .seg_in (seg_s2_q),
      .code   (enc_code),
      .dot    (enc_dot)
   );

   always_comb begin
      seg_s1_d = SEG_IN;
      sel_s1_d = DIG_SEL;
      seg_s2_d = seg_s1_q;
      sel_s2_d = sel_s1_q;

      sel_inv   = ~sel_s2_q;
      // Exactly one bit set in the inverted select.
      sel_valid = (sel_inv != '0) && ((sel_inv & (sel_inv - NDIG'(1))) == '0);
      pair_same = (seg_s2_q == seg_ref_q) && (sel_s2_q == sel_ref_q);

      state_d   = state_q;
      cnt_d     = cnt_q;
      seg_ref_d = seg_ref_q;
      sel_ref_d = sel_ref_q;
      capture   = 1'b0;

      case (state_q)
         S_WAIT: begin
            if (sel_valid) begin
               state_d   = S_SETTLE;
               cnt_d     = 8'd1;
               seg_ref_d = seg_s2_q;
               sel_ref_d = sel_s2_q;
            end
         end
         S_SETTLE: begin
            if (!sel_valid) begin
               state_d = S_WAIT;
               cnt_d   = 8'd0;
            end else if (!pair_same) begin
               cnt_d     = 8'd1;
               seg_ref_d = seg_s2_q;
               sel_ref_d = sel_s2_q;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = S_HOLD;
               cnt_d   = cnt_q + 8'd1;
               capture = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_HOLD: begin
            if (!pair_same) begin
               if (sel_valid) begin
                  state_d   = S_SETTLE;
                  cnt_d     = 8'd1;
                  seg_ref_d = seg_s2_q;
                  sel_ref_d = sel_s2_q;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 8'd0;
               end
            end
         end
         default: begin
            state_d = S_WAIT;
            cnt_d   = 8'd0;
         end
      endcase

      dout_d = dout_q;
      dot_d  = dot_q;
      for (int i = 0; i < NDIG; i++) begin
         if (capture && !sel_s2_q[i]) begin
            dout_d[4*i +: 4] = enc_code;
            dot_d[i]         = enc_dot;
         end
      end

      // A full mask pulses FRAME_VALID and restarts; a capture on that same
      // edge lands in the fresh mask.
      fv_d   = &mask_q;
      mask_d = ((&mask_q) ? '0 : mask_q) | (capture ? sel_inv : '0);

`ifdef SEG7MON_ERR_EN
      err_d = err_q | (capture && (enc_code == CODE_INVALID));
`else
      err_d = 1'b0;
`endif
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         seg_s1_q  <= '1;
         seg_s2_q  <= '1;
         sel_s1_q  <= '1;
         sel_s2_q  <= '1;
         seg_ref_q <= '1;
         sel_ref_q <= '1;
         state_q   <= S_WAIT;
         cnt_q     <= 8'd0;
         dout_q    <= {NDIG{CODE_BLANK}};
         dot_q     <= '0;
         mask_q    <= '0;
         fv_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         seg_s1_q  <= seg_s1_d;
         seg_s2_q  <= seg_s2_d;
         sel_s1_q  <= sel_s1_d;
         sel_s2_q  <= sel_s2_d;
         seg_ref_q <= seg_ref_d;
         sel_ref_q <= sel_ref_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dout_q    <= dout_d;
         dot_q     <= dot_d;
         mask_q    <= mask_d;
         fv_q      <= fv_d;
         err_q     <= err_d;
      end
   end

   assign DOUT        = dout_q;
   assign DOT_OUT     = dot_q;
   assign FRAME_VALID = fv_q;
   assign ERR         = err_q;

endmodule

// File: tb/tb_seg7_mon.sv
// tb_seg7_mon -- scoreboard bench for seg7_mon. Stimulus is a sequence of
// "runs" (a segment/select pair held for N cycles). A run with one digit
// selected and held at least STABLE_CYC cycles is captured 2+STABLE_CYC
// cycles after it appears on the pins; those captures are queued and a
// negedge monitor applies them to a display model and compares outputs.
module tb_seg7_mon;

   localparam int NDIG = 4;
   localparam int SC   = 4;
   localparam int LAT  = 2 + SC;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic [7:0]  SEG_IN = 8'hFF;
   logic [3:0]  DIG_SEL = 4'hF;
   logic [15:0] DOUT;
   logic [3:0]  DOT_OUT;
   logic        FRAME_VALID;
   logic        ERR;

   seg7_mon #(.NDIG(NDIG), .STABLE_CYC(SC)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .SEG_IN      (SEG_IN),
      .DIG_SEL     (DIG_SEL),
      .DOUT        (DOUT),
      .DOT_OUT     (DOT_OUT),
      .FRAME_VALID (FRAME_VALID),
      .ERR         (ERR)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int         at;
      int         dig;
      logic [3:0] code;
      logic       dot;
   } cap_t;

   cap_t exp_q[$];

   int n_checks = 0;
   int n_err    = 0;
   int fv_count = 0;

   logic [6:0] pats [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   // display model
   logic [15:0] m_dout;
   logic [3:0]  m_dot;
   logic [3:0]  seen;
   logic        frame_done;
   logic        m_err;

   logic [3:0]  prev_sel;
   logic [7:0]  prev_seg;

`ifdef SEG7MON_ERR_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   function automatic logic [3:0] ref_code(input logic [7:0] s);
      for (int k = 0; k < 10; k++)
         if (s[6:0] == pats[k]) return 4'(k);
      if (s[6:0] == 7'h7F) return 4'hA;
      return 4'hF;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic model_reset();
      m_dout     = 16'hAAAA;
      m_dot      = 4'h0;
      seen       = 4'h0;
      frame_done = 1'b0;
      m_err      = 1'b0;
      prev_sel   = 4'hF;
      prev_seg   = 8'hFF;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Drive a pair that the caller promises to hold for len cycles.
   task automatic apply(input logic [3:0] sel, input logic [7:0] seg, input int len);
      cap_t ev;
      logic [3:0] inv;
      SEG_IN  = seg;
      DIG_SEL = sel;
      inv = ~sel;
      if ($countones(inv) == 1 && len >= SC) begin
         ev.dig = 0;
         for (int i = 0; i < NDIG; i++) if (inv[i]) ev.dig = i;
         ev.at   = cyc + LAT;
         ev.code = ref_code(seg);
         ev.dot  = ~seg[7];
         exp_q.push_back(ev);
      end
      prev_sel = sel;
      prev_seg = seg;
   endtask

   task automatic run(input logic [3:0] sel, input logic [7:0] seg, input int len);
      apply(sel, seg, len);
      step(len);
   endtask

   // Asserts reset a couple of ns after an edge, checks the asynchronous
   // effect, then releases right after a later edge.
   task automatic do_reset(input int hold);
      #2;
      nRST    = 1'b0;
      SEG_IN  = 8'hFF;
      DIG_SEL = 4'hF;
      exp_q.delete();
      model_reset();
      #1;
      check("rst_dout", DOUT, 16'hAAAA);
      check("rst_dot", DOT_OUT, 4'h0);
      check("rst_fv", FRAME_VALID, 1'b0);
      check("rst_err", ERR, 1'b0);
      step(hold);
      nRST = 1'b1;
      step(2);
   endtask

   always @(negedge CLK) begin
      cap_t ev;
      logic fv_exp;
      fv_exp = frame_done;
      if (frame_done) begin
         seen       = 4'h0;
         frame_done = 1'b0;
      end
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
         ev = exp_q.pop_front();
         check("capture_missed_at", 32'(ev.at), 32'(cyc));
      end
      if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
         ev = exp_q.pop_front();
         m_dout[4*ev.dig +: 4] = ev.code;
         m_dot[ev.dig]         = ev.dot;
         seen[ev.dig]          = 1'b1;
         if (ev.code == 4'hF && ERR_ON) m_err = 1'b1;
         if (&seen) frame_done = 1'b1;
      end
      if (FRAME_VALID === 1'b1) fv_count++;
      check("dout", DOUT, m_dout);
      check("dot_out", DOT_OUT, m_dot);
      check("frame_valid", FRAME_VALID, fv_exp);
      check("err", ERR, m_err);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] sel;
      logic [7:0] seg;
      int         len;
      int         r;
      model_reset();
      step(1);
      do_reset(2);

      // Test 1: latency of exactly 2+STABLE_CYC cycles.
      apply(4'b1110, 8'hC0, 10);
      step(5);
      check("t1_before_latency", DOUT[3:0], 4'hA);
      step(1);
      check("t1_nibble0", DOUT[3:0], 4'h0);
      check("t1_dot0", DOT_OUT[0], 1'b0);
      check("t1_others", DOUT[15:4], 12'hAAA);
      step(4);

      // Test 2: full scan from a clean mask.
      do_reset(2);
      fv_count = 0;
      run(4'b1110, 8'hF9, 8);
      run(4'b1101, 8'hA4, 8);
      run(4'b1011, 8'hB0, 8);
      run(4'b0111, 8'h99, 8);
      run(4'b1111, 8'hFF, 2);
      check("t2_dout", DOUT, 16'h4321);
      check("t2_fv_pulses", fv_count, 1);

      // Test 3: segments toggle faster than the stability window.
      for (int k = 0; k < 10; k++)
         run(4'b1101, (k % 2 == 1) ? 8'hA4 : 8'hF9, 3);
      check("t3_dout", DOUT, 16'h4321);

      // Test 4: two digits selected at once.
      run(4'b1100, 8'h92, 20);
      check("t4_dout", DOUT, 16'h4321);

      // Test 5: invalid pattern on digit 2.
      run(4'b1011, 8'h3F, 8);
      check("t5_nibble2", DOUT[11:8], 4'hF);
      check("t5_dot2", DOT_OUT[2], 1'b1);
      check("t5_err", ERR, ERR_ON);

      // Test 6: reset in the middle of settling.
      apply(4'b0111, 8'h40, 4);
      step(4);
      fv_count = 0;
      do_reset(3);
      step(4);
      check("t6_no_fv", fv_count, 0);
      check("t6_dout", DOUT, 16'hAAAA);

      // Randomized runs.
      for (int n = 0; n < 250; n++) begin
         r = $urandom_range(0, 9);
         if (r < 7) sel = ~(4'b0001 << $urandom_range(0, 3));
         else       sel = 4'($urandom);
         r = $urandom_range(0, 9);
         seg = 8'($urandom);
         if (r < 6)      seg[6:0] = pats[$urandom_range(0, 9)];
         else if (r < 7) seg[6:0] = 7'h7F;
         if (sel == prev_sel && seg == prev_seg) seg = seg ^ 8'h80;
         len = $urandom_range(1, 9);
         run(sel, seg, len);
      end
      run(4'b1111, 8'hFF, LAT + 4);
      check("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/seg7_mon.md
SEG7_MON -- requirements
Module: seg7_mon

Interface
REQ-001 The block SHALL have parameter NDIG, default 4, giving the number of multiplexed digits monitored (1..8).
REQ-002 The block SHALL have parameter STABLE_CYC, default 4, giving the consecutive stable cycles required before capture (2..255).
REQ-003 The block SHALL have port CLK, input, 1, the single clock; all flops are rising-edge.
REQ-004 The block SHALL have port nRST, input, 1, an asynchronous active-low reset.
REQ-005 The block SHALL have port SEG_IN, input, 8, the active-low segment bus: bit7 is dot, bits6:0 are segments g..a.
REQ-006 The block SHALL have port DIG_SEL, input, NDIG, the active-low digit enables; bit i low selects digit i.
REQ-007 The block SHALL have port DOUT, output, 4*NDIG, the decoded code per digit, with digit i at bits 4i+3:4i.
REQ-008 The block SHALL have port DOT_OUT, output, NDIG, set when digit i's last captured dot was lit.
REQ-009 The block SHALL have port FRAME_VALID, output, 1, a one-cycle pulse when every digit has been captured since the last pulse.
REQ-010 The block SHALL have port ERR, output, 1, a sticky invalid-pattern flag (see Configuration).

Function
REQ-011 SEG_IN and DIG_SEL SHALL pass through a 2-flop synchronizer; all logic below uses the synchronized values.
REQ-012 A select SHALL be valid only when exactly one DIG_SEL bit is low.
REQ-013 The FSM SHALL have states WAIT, SETTLE and HOLD.
  - WAIT -> SETTLE on a valid select; the settle counter loads 1 and the (SEG, DIG_SEL) pair is latched as the reference.
  - SETTLE: the counter increments while the synced pair equals the reference.
  - SETTLE -> WAIT on an invalid select.
  - SETTLE -> SETTLE with a reload to 1 and a new reference when the pair changes but the select is still valid.
  - SETTLE -> HOLD when the counter reaches STABLE_CYC; the capture occurs on that edge.
  - HOLD -> WAIT or SETTLE (rules as for WAIT) as soon as the pair differs from the reference; while the pair is unchanged there is no re-capture.
REQ-014 Capture SHALL write the decoded code into the DOUT nibble of the selected digit and the dot into DOT_OUT[i]; other digits SHALL be unchanged.
REQ-015 Pin-to-output latency SHALL be 2+STABLE_CYC cycles for a stable pattern.
REQ-016 The decode map for SEG_IN[6:0] SHALL be as follows; the dot is SEG_IN[7]==0.
  - 0x40 -> 0, 0x79 -> 1, 0x24 -> 2, 0x30 -> 3, 0x19 -> 4, 0x12 -> 5.
  - 0x02 -> 6, 0x78 -> 7, 0x00 -> 8, 0x10 -> 9.
  - 0x7F (blank) -> 4'hA.
  - Any other pattern -> 4'hF (invalid).
REQ-017 A captured-mask of NDIG bits SHALL set bit i on each capture of digit i.
REQ-018 When the mask becomes all-ones, FRAME_VALID SHALL pulse on the next cycle and the mask SHALL clear; a capture coinciding with the clear SHALL set its bit in the fresh mask.
REQ-019 A re-capture of an already-masked digit before the frame completes SHALL update DOUT but SHALL NOT pulse FRAME_VALID.

Reset
REQ-020 nRST low SHALL asynchronously force the following, independent of the current state:
  - synchronizers to the idle value (all ones);
  - FSM to WAIT and the counter to 0;
  - DOUT to all nibbles 4'hA, DOT_OUT to 0 and the mask to 0;
  - FRAME_VALID to 0 and ERR to 0.
REQ-021 Reset deassertion SHALL release on the next CLK edge with no spurious FRAME_VALID.

Configuration
REQ-022 With macro SEG7MON_ERR_EN defined, a capture decoding to 4'hF SHALL set ERR, which remains 1 until reset.
REQ-023 Without SEG7MON_ERR_EN, ERR SHALL be constant 0; invalid patterns still decode to 4'hF.

Structure
REQ-024 Package seg7_pkg SHALL hold the ten digit pattern constants, the blank pattern, the code constants (CODE_BLANK=4'hA, CODE_INVALID=4'hF) and the FSM state enum.
REQ-025 Sub-module seg7_enc SHALL be the purely combinational pattern-to-code decoder (8-bit in, 4-bit code plus dot out), instantiated once.

Verification
REQ-026 Directed test 1: DIG_SEL=4'b1110, SEG_IN=8'hC0 held 10 cycles -> DOUT[3:0]=0 and DOT_OUT[0]=0 exactly 6 cycles after the inputs change; other nibbles remain 4'hA.
REQ-027 Directed test 2: scan digits 0..3 with 0x79, 0x24, 0x30, 0x19 and 8 cycles each -> DOUT=16'h4321 and one FRAME_VALID pulse after digit 3's capture.
REQ-028 Directed test 3: SEG_IN toggles every 3 cycles under one select (STABLE_CYC=4) -> no capture and DOUT unchanged.
REQ-029 Directed test 4: DIG_SEL=4'b1100 (two selected) for 20 cycles -> FSM stays in WAIT with no capture.
REQ-030 Directed test 5: SEG_IN=8'h3F stable on digit 2 -> nibble 2 = 4'hF; ERR=1 with SEG7MON_ERR_EN and ERR=0 without it.
REQ-031 Directed test 6: assert nRST mid-SETTLE -> all outputs return to reset values immediately with no FRAME_VALID after release.
